snitch_regfile_lvt: RTL
=======================

Name: snitch_regfile_lvt

Overview:
Multi-write-port, multi-read-port register file for FPGA targets. Storage is one distributed-RAM bank per write port, and a live-value table (LVT) selects which bank holds each register's current value. Adds what the previous generation lacks: parametrised address width, optional write-to-read bypass, and a sequential zero-initialisation/flush engine, since distributed RAM has no reset. Instantiated as the integer/FP register file in Snitch cores built for FPGA.

Parameters:
DataWidth, 32, bits per register
AddrWidth, 5, register address width; NumWords = 2**AddrWidth
NrReadPorts, 2, async read ports (>=1)
NrWritePorts, 2, sync write ports (>=1); LvtWidth = max(1, $clog2(NrWritePorts))
ZeroRegZero, 0, 1: reads of address 0 return 0
Bypass, 0, 1: a read returns this cycle's write data for a matching address

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  request re-initialisation of all registers to 0
ready_o  out  1  1 = initialised; writes accepted, reads valid
raddr_i  in  NrReadPorts x AddrWidth  read addresses
rdata_o  out  NrReadPorts x DataWidth  read data (combinational)
waddr_i  in  NrWritePorts x AddrWidth  write addresses
wdata_i  in  NrWritePorts x DataWidth  write data
we_i  in  NrWritePorts  write enables

Behaviour:
- FSM states: INIT, READY. Reset (asynchronous) -> INIT, init counter = 0, ready_o = 0, all LVT flops = 0.
- INIT: each cycle writes 0 to word `counter` in every bank and sets LVT[counter] = 0; counter increments. After writing word NumWords-1, next state is READY. ready_o goes high exactly NumWords cycles after reset release.
- READY + flush_i = 1 -> INIT with counter = 0, so ready_o is low the following cycle. flush_i during INIT restarts counter at 0. flush_i has priority over we_i in the same cycle, and those writes are dropped.
- While ready_o = 0: we_i is ignored and rdata_o = 0 on all ports. Callers gate writes on ready_o; no backpressure beyond that.
- Write (READY): for each port j with we_i[j], bank j word waddr_i[j] <= wdata_i[j] at the clock edge. LVT[waddr_i[j]] <= j. If several ports write the same address in one cycle, the highest-index port wins the LVT, so that value is the visible one.
- Read: rdata_o[k] = bank[LVT[raddr_i[k]]][raddr_i[k]].
  - Bypass = 0: a same-cycle write is visible from the next cycle.
  - Bypass = 1: if some port writes raddr_i[k] in this cycle (READY only), output the highest-index such port's wdata.
- ZeroRegZero = 1: a read with raddr_i[k] == 0 returns 0, overriding bypass. Writes to address 0 are still stored, harmlessly.
- No internal pipelining: write latency 1 cycle, read latency 0.
- Reset mid-INIT or mid-write: restart INIT from counter 0. Partial data contents are don't-care because INIT overwrites them.
- Banks hold no reset. Only the FSM, counter and LVT flops are reset.

Test Plan:
- Reset release with AddrWidth=5 -> ready_o = 0 for 32 cycles, 1 on cycle 33. All 32 addresses then read 0 on every port.
- NrWritePorts=2: port0 writes addr 3 = 0xAAAA_0000, next cycle port1 writes addr 3 = 0x5555_1111 -> reads of addr 3 return 0xAAAA_0000, then 0x5555_1111.
- Same cycle: port0 writes addr 7 = 0x1, port1 writes addr 7 = 0x2 -> addr 7 reads 0x2 next cycle.
- Bypass=1: write addr 9 = 0xDEAD_BEEF while reading addr 9 -> rdata 0xDEAD_BEEF in the same cycle. With Bypass=0 -> old value that cycle, new value the next.
- ZeroRegZero=1: write addr 0 = 0xFFFF_FFFF -> reads of addr 0 return 0, including under Bypass=1.
- Registers loaded with nonzero data, flush_i pulsed 1 cycle -> ready_o low for 32 cycles, writes during that window are dropped, and all registers read 0 afterwards. A second flush mid-INIT extends the low window to 32 cycles from that flush.

Source files
------------

// File: rtl/snitch_regfile_lvt_if.sv
// Register-file access bundle: flush request, init status and the read/write
// port arrays.
//   master : the core side, which drives addresses, write data/enables and flush
//   slave  : the register file, which drives ready_o and rdata_o
interface snitch_regfile_lvt_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 5,
  parameter int unsigned NrReadPorts  = 2,
  parameter int unsigned NrWritePorts = 2
);
  logic                                    flush_i;
  logic                                    ready_o;
  logic [NrReadPorts-1:0][AddrWidth-1:0]   raddr_i;
  logic [NrReadPorts-1:0][DataWidth-1:0]   rdata_o;
  logic [NrWritePorts-1:0][AddrWidth-1:0]  waddr_i;
  logic [NrWritePorts-1:0][DataWidth-1:0]  wdata_i;
  logic [NrWritePorts-1:0]                 we_i;

  modport master (output flush_i, raddr_i, waddr_i, wdata_i, we_i,
                  input  ready_o, rdata_o);
  modport slave  (input  flush_i, raddr_i, waddr_i, wdata_i, we_i,
                  output ready_o, rdata_o);
endinterface

// File: rtl/snitch_regfile_lvt.sv
// LVT-based multi-port register file for FPGA distributed RAM.
// There is one RAM bank per write port. A live-value table records which bank
// holds the newest copy of each word. Because the banks have no reset, an
// INIT sweep zeroes every word one per cycle after reset and after each flush.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   bus (slave)   : flush_i/ready_o, raddr_i/rdata_o (async read),
//                   waddr_i/wdata_i/we_i (sync write)

// One read lane. It picks the live bank and then applies the optional bypass
// and the optional hard-wired zero for address 0.
module snitch_regfile_lvt_rd #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 5,
  parameter int unsigned NrWritePorts = 2,
  parameter int unsigned LvtWidth     = 1,
  parameter bit          ZeroRegZero  = 1'b0,
  parameter bit          Bypass       = 1'b0
) (
  input  logic                                   ready_i,
  input  logic [AddrWidth-1:0]                   raddr_i,
  input  logic [LvtWidth-1:0]                    sel_i,
  input  logic [NrWritePorts-1:0][DataWidth-1:0] bank_i,
  input  logic [NrWritePorts-1:0]                wr_en_i,
  input  logic [NrWritePorts-1:0][AddrWidth-1:0] waddr_i,
  input  logic [NrWritePorts-1:0][DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0]                   rdata_o
);
  always_comb begin
    rdata_o = '0;
    if (ready_i) begin
      rdata_o = bank_i[sel_i];
      // Ascending scan, so the highest-index matching port wins, as in the LVT.
      if (Bypass) begin
        for (int j = 0; j < NrWritePorts; j++)
          if (wr_en_i[j] && waddr_i[j] == raddr_i) rdata_o = wdata_i[j];
      end
      if (ZeroRegZero && raddr_i == '0) rdata_o = '0;
    end
  end
endmodule

module snitch_regfile_lvt #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 5,
  parameter int unsigned NrReadPorts  = 2,
  parameter int unsigned NrWritePorts = 2,
  parameter bit          ZeroRegZero  = 1'b0,
  parameter bit          Bypass       = 1'b0
) (
  input logic               clk_i,
  input logic               rst_ni,
  snitch_regfile_lvt_if.slave bus
);
  localparam int unsigned NumWords = 2**AddrWidth;
  localparam int unsigned LvtWidth = (NrWritePorts > 1) ? $clog2(NrWritePorts) : 1;

  typedef enum logic {INIT, READY} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   cnt_q, cnt_d;
  logic                   init, ready;
  logic [NrWritePorts-1:0] wr_en;
  logic [NumWords-1:0][LvtWidth-1:0] lvt_q;
  logic [NrReadPorts-1:0][NrWritePorts-1:0][DataWidth-1:0] bank_q;
  logic [NrReadPorts-1:0][DataWidth-1:0] rdata;

  assign init  = (state_q == INIT);
  assign ready = (state_q == READY);
  // A flush in the same cycle drops the writes.
  assign wr_en = bus.we_i & {NrWritePorts{ready & ~bus.flush_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = READY;
      end
      default: ;
    endcase
    if (bus.flush_i) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  // Assignments run in ascending port order, so the highest port owns the word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvt_q <= '0;
    end else if (init) begin
      lvt_q[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NrWritePorts; j++)
        if (wr_en[j]) lvt_q[bus.waddr_i[j]] <= LvtWidth'(j);
    end
  end

  for (genvar j = 0; j < NrWritePorts; j++) begin : g_bank
    logic [DataWidth-1:0] mem [NumWords];
    always_ff @(posedge clk_i) begin
      if (init)          mem[cnt_q]           <= '0;
      else if (wr_en[j]) mem[bus.waddr_i[j]]  <= bus.wdata_i[j];
    end
    for (genvar k = 0; k < NrReadPorts; k++) begin : g_rd
      assign bank_q[k][j] = mem[bus.raddr_i[k]];
    end
  end

  for (genvar k = 0; k < NrReadPorts; k++) begin : g_lane
    snitch_regfile_lvt_rd #(
      .DataWidth(DataWidth), .AddrWidth(AddrWidth), .NrWritePorts(NrWritePorts),
      .LvtWidth(LvtWidth), .ZeroRegZero(ZeroRegZero), .Bypass(Bypass)
    ) i_rd (
      .ready_i (ready),
      .raddr_i (bus.raddr_i[k]),
      .sel_i   (lvt_q[bus.raddr_i[k]]),
      .bank_i  (bank_q[k]),
      .wr_en_i (wr_en),
      .waddr_i (bus.waddr_i),
      .wdata_i (bus.wdata_i),
      .rdata_o (rdata[k])
    );
  end

  assign bus.rdata_o = rdata;
  assign bus.ready_o = ready;
endmodule
